pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//   Fetch-side consumer of the next-PC/redirect pair driven by next-PC logic in decode.
//   - Holds the architectural PC and drives the instruction-memory address.
//   - Applies sequential or redirected PC updates.
//   - Absorbs instruction-memory wait cycles and hazard stalls.
//   - Loads the IF/ID pipeline register.
// PARAMETERS
//   RESET_PC    32'h0000_3000  PC value after reset
//   DELAY_SLOT  1              1: instr after a branch/jump executes; 0: it is squashed (bubble)
//   EXC_VEC     32'h0000_4180  misaligned-target vector (used only with PC_ALIGN_CHECK_EN)
// PORTS
//   clk            in   1   clock, rising edge
//   reset          in   1   synchronous, active-high
//   npc            in   32  redirect target from decode-stage next-PC logic
//   boj            in   1   branch/jump redirect request; valid only when stall=0
//   stall          in   1   hazard-unit stall: hold PC and IF/ID
//   imem_rdy       in   1   imem_instr valid for current pc this cycle
//   imem_instr     in   32  fetched instruction
//   pc             out  32  fetch address to instruction memory
//   if_instr       out  32  IF/ID instruction (0 = nop when bubble)
//   if_pc          out  32  IF/ID PC of if_instr
//   if_pc4         out  32  IF/ID if_pc+4
//   if_valid       out  1   IF/ID holds a real instruction
//   redirect_pend  out  1   redirect target latched, waiting for memory
//   adel           out  1   (PC_ALIGN_CHECK_EN only) 1-cycle misaligned-target pulse
//   epc            out  32  (PC_ALIGN_CHECK_EN only) last offending target
// BEHAVIOUR
//   Reset:
//     - pc=RESET_PC; if_instr, if_pc, if_pc4, epc = 0.
//     - if_valid, redirect_pend, adel = 0; state=RUN.
//     - Reset mid-wait discards any pending target.
//   States:
//     - RUN: fetch completing normally.
//     - WAIT: fetch outstanding, no target pending.
//     - REDIR: fetch outstanding, target pending (redirect_pend=1 exactly in REDIR).
//   Priority per cycle: reset > stall > memory-wait > redirect > sequential.
//   stall=1:
//     - pc, IF/ID and state all hold; boj ignored.
//     - Decode re-asserts boj after the stall clears.
//   stall=0, imem_rdy=0:
//     - pc holds; IF/ID <= bubble (if_valid=0, if_instr=0; if_pc/if_pc4 hold).
//     - boj=1 -> pend_tgt<=npc, go REDIR; else RUN->WAIT, WAIT->WAIT, REDIR->REDIR.
//     - A later boj in REDIR overwrites pend_tgt.
//   stall=0, imem_rdy=1:
//     - Accept: if_instr=imem_instr, if_pc=pc, if_pc4=pc+4, if_valid=1.
//     - Squash (DELAY_SLOT=0 and (boj=1 or state=REDIR)): load bubble instead.
//     - Next pc: boj ? npc : (state==REDIR ? pend_tgt : pc+4); next state RUN.
//   Latency: a redirect accepted in cycle N presents npc on pc in cycle N+1.
//   Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
//   pc[1:0] is always 2'b00 on the output.
// CONFIGURATION
//   PC_ALIGN_CHECK_EN defined:
//     - A chosen target (npc or pend_tgt) with bits[1:0]!=0 is replaced by EXC_VEC.
//     - adel pulses 1 cycle; epc <= offending target.
//     - If DELAY_SLOT=1, the accepted delay-slot instr is kept.
//   PC_ALIGN_CHECK_EN undefined:
//     - Target bits[1:0] forced to 0.
//     - adel and epc ports absent.
// TESTING
//   1. Reset then 4 cycles imem_rdy=1 -> pc 3000,3004,3008,300C; if_pc lags pc by one cycle.
//   2. boj=1, npc=3100 while pc=3008 -> next pc=3100.
//      - DELAY_SLOT=1: if_pc=3008, if_valid=1.
//      - DELAY_SLOT=0: if_valid=0.
//   3. stall=1 for 3 cycles with boj=1 -> pc and IF/ID frozen, boj ignored; resumes at pc+4.
//   4. imem_rdy=0, boj=1, npc=3200, then imem_rdy=0 for 2 cycles, then 1.
//      - redirect_pend=1 through the wait.
//      - pc=3200 the cycle after imem_rdy rises.
//   5. pc=FFFF_FFFC, no redirect -> next pc=0000_0000.
//   6. PC_ALIGN_CHECK_EN: npc=3102 with boj -> pc=4180, adel=1 one cycle, epc=3102.
//      Reset asserted while in REDIR -> pc=3000, redirect_pend=0.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: decode/imem to fetch-control bus; adel/epc exist only with PC_ALIGN_CHECK_EN
interface pc_fetch_ctrl_if;
    logic [31:0] npc;
    logic        boj;
    logic        stall;
    logic        imem_rdy;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic        redirect_pend;
`ifdef PC_ALIGN_CHECK_EN
    logic        adel;
    logic [31:0] epc;
    modport master (output npc, boj, stall, imem_rdy, imem_instr,
                    input pc, if_instr, if_pc, if_pc4, if_valid, redirect_pend, adel, epc);
    modport slave  (input npc, boj, stall, imem_rdy, imem_instr,
                    output pc, if_instr, if_pc, if_pc4, if_valid, redirect_pend, adel, epc);
`else
    modport master (output npc, boj, stall, imem_rdy, imem_instr,
                    input pc, if_instr, if_pc, if_pc4, if_valid, redirect_pend);
    modport slave  (input npc, boj, stall, imem_rdy, imem_instr,
                    output pc, if_instr, if_pc, if_pc4, if_valid, redirect_pend);
`endif
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC register, redirect/wait handling and IF/ID load; PC_ALIGN_CHECK_EN traps misaligned targets
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
`ifdef PC_ALIGN_CHECK_EN
    parameter logic [31:0] EXC_VEC    = 32'h0000_4180,
`endif
    parameter int          DELAY_SLOT = 1
) (
    input logic clk,
    input logic reset,
    pc_fetch_ctrl_if.slave bus
);
    localparam logic [1:0] RUN = 2'd0, WAIT = 2'd1, REDIR = 2'd2;
    logic [1:0]  state;
    logic [31:0] pend_tgt, raw, tgt;
    logic        take, squash, mis;
    always_comb begin
        raw    = bus.boj ? bus.npc : pend_tgt;
        take   = bus.boj || state == REDIR;
        squash = DELAY_SLOT == 0 && take;
        mis    = raw[1:0] != 2'b00;
`ifdef PC_ALIGN_CHECK_EN
        tgt    = mis ? EXC_VEC : raw;
`else
        tgt    = raw & 32'hFFFF_FFFC;
`endif
    end
    assign bus.redirect_pend = state == REDIR;
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.pc       <= RESET_PC;
            bus.if_instr <= '0;
            bus.if_pc    <= '0;
            bus.if_pc4   <= '0;
            bus.if_valid <= 1'b0;
            pend_tgt     <= '0;
            state        <= RUN;
`ifdef PC_ALIGN_CHECK_EN
            bus.adel     <= 1'b0;
            bus.epc      <= '0;
`endif
        end else begin
`ifdef PC_ALIGN_CHECK_EN
            bus.adel <= 1'b0;
`endif
            if (!bus.stall && !bus.imem_rdy) begin
                bus.if_valid <= 1'b0;
                bus.if_instr <= '0;
                pend_tgt     <= bus.boj ? bus.npc : pend_tgt;
                state        <= bus.boj ? REDIR : (state == RUN ? WAIT : state);
            end else if (!bus.stall) begin
                bus.if_valid <= !squash;
                bus.if_instr <= squash ? '0 : bus.imem_instr;
                bus.if_pc    <= squash ? bus.if_pc : bus.pc;
                bus.if_pc4   <= squash ? bus.if_pc4 : bus.pc + 32'd4;
                bus.pc       <= take ? tgt : bus.pc + 32'd4;
                state        <= RUN;
`ifdef PC_ALIGN_CHECK_EN
                bus.adel     <= take && mis;
                bus.epc      <= take && mis ? raw : bus.epc;
`endif
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed spec scenarios plus random traffic on DELAY_SLOT=0 and =1 instances vs a model
module tb_pc_fetch_ctrl;
    logic clk = 1'b0, reset = 1'b1, boj = 1'b0, stall = 1'b0, rdy = 1'b1, en = 1'b0;
    logic [31:0] npc = '0, instr = '0;
    int errors = 0, checks = 0;
    always #5 clk = ~clk;

    pc_fetch_ctrl_if b0 ();
    pc_fetch_ctrl_if b1 ();
    assign b0.npc = npc;   assign b1.npc = npc;
    assign b0.boj = boj;   assign b1.boj = boj;
    assign b0.stall = stall; assign b1.stall = stall;
    assign b0.imem_rdy = rdy; assign b1.imem_rdy = rdy;
    assign b0.imem_instr = instr; assign b1.imem_instr = instr;

    pc_fetch_ctrl #(.DELAY_SLOT(0)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
    pc_fetch_ctrl #(.DELAY_SLOT(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));

    logic [31:0] m_pc[2], m_tgt[2], m_ii[2], m_ip[2], m_ip4[2], m_epc[2];
    logic        m_pend[2], m_iv[2], m_adel[2];

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ds=%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
        end
    endtask

    task automatic step(input int d);
        logic [31:0] t;
        logic redir;
        m_adel[d] = 1'b0;
        if (reset) begin
            m_pc[d] = 32'h3000; m_pend[d] = 0; m_tgt[d] = 0;
            m_ii[d] = 0; m_ip[d] = 0; m_ip4[d] = 0; m_iv[d] = 0; m_epc[d] = 0;
        end else if (stall) begin
        end else if (!rdy) begin
            m_iv[d] = 0; m_ii[d] = 0;
            if (boj) begin m_pend[d] = 1; m_tgt[d] = npc; end
        end else begin
            redir = boj || m_pend[d];
            t = boj ? npc : m_tgt[d];
            if (d == 0 && redir) begin
                m_iv[d] = 0; m_ii[d] = 0;
            end else begin
                m_ii[d] = instr; m_ip[d] = m_pc[d]; m_ip4[d] = m_pc[d] + 32'd4; m_iv[d] = 1;
            end
            if (redir) begin
`ifdef PC_ALIGN_CHECK_EN
                if (t[1:0] != 2'b00) begin
                    m_adel[d] = 1'b1; m_epc[d] = t; t = 32'h4180;
                end
`else
                t[1:0] = 2'b00;
`endif
                m_pc[d] = t;
            end else m_pc[d] = m_pc[d] + 32'd4;
            m_pend[d] = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        step(0);
        step(1);
        #2;
    endtask

    task automatic cmp(input int d, input logic [31:0] p, ii, ip, ip4, input logic v, rp);
        chk("pc", d, p, m_pc[d]);
        chk("if_instr", d, ii, m_ii[d]);
        chk("if_pc", d, ip, m_ip[d]);
        chk("if_pc4", d, ip4, m_ip4[d]);
        chk("if_valid", d, {31'b0, v}, {31'b0, m_iv[d]});
        chk("redirect_pend", d, {31'b0, rp}, {31'b0, m_pend[d]});
    endtask

    always @(negedge clk) if (en) begin
        cmp(0, b0.pc, b0.if_instr, b0.if_pc, b0.if_pc4, b0.if_valid, b0.redirect_pend);
        cmp(1, b1.pc, b1.if_instr, b1.if_pc, b1.if_pc4, b1.if_valid, b1.redirect_pend);
`ifdef PC_ALIGN_CHECK_EN
        chk("adel", 0, {31'b0, b0.adel}, {31'b0, m_adel[0]});
        chk("adel", 1, {31'b0, b1.adel}, {31'b0, m_adel[1]});
        chk("epc", 0, b0.epc, m_epc[0]);
        chk("epc", 1, b1.epc, m_epc[1]);
`endif
    end

    initial begin
        instr = 32'hA000_0000;
        cyc();
        en = 1'b1;
        chk("rst_pc", 1, b1.pc, 32'h3000);
        chk("rst_valid", 1, {31'b0, b1.if_valid}, 32'd0);
        chk("rst_if_pc", 1, b1.if_pc, 32'd0);
        reset = 1'b0;
        for (int i = 1; i < 3; i++) begin
            instr = 32'hA000_0000 + i;
            cyc();
            chk("seq_pc", 1, b1.pc, 32'h3000 + 4 * i);
            chk("seq_if_pc", 1, b1.if_pc, 32'h3000 + 4 * (i - 1));
        end
        boj = 1'b1; npc = 32'h3100;
        cyc();
        chk("br_pc", 1, b1.pc, 32'h3100);
        chk("br_pc", 0, b0.pc, 32'h3100);
        chk("br_if_pc", 1, b1.if_pc, 32'h3008);
        chk("br_valid", 1, {31'b0, b1.if_valid}, 32'd1);
        chk("br_valid", 0, {31'b0, b0.if_valid}, 32'd0);
        stall = 1'b1; npc = 32'h3500;
        repeat (3) begin
            cyc();
            chk("stall_pc", 1, b1.pc, 32'h3100);
            chk("stall_if_pc", 1, b1.if_pc, 32'h3008);
        end
        stall = 1'b0; boj = 1'b0;
        cyc();
        chk("resume_pc", 1, b1.pc, 32'h3104);
        chk("resume_if_pc", 1, b1.if_pc, 32'h3100);
        rdy = 1'b0; boj = 1'b1; npc = 32'h3200;
        cyc();
        chk("wait_pend", 1, {31'b0, b1.redirect_pend}, 32'd1);
        chk("wait_pc", 1, b1.pc, 32'h3104);
        boj = 1'b0;
        repeat (2) begin
            cyc();
            chk("wait_pend2", 0, {31'b0, b0.redirect_pend}, 32'd1);
        end
        rdy = 1'b1;
        cyc();
        chk("redir_pc", 1, b1.pc, 32'h3200);
        chk("redir_pend", 1, {31'b0, b1.redirect_pend}, 32'd0);
        chk("redir_ds_valid", 1, {31'b0, b1.if_valid}, 32'd1);
        chk("redir_sq_valid", 0, {31'b0, b0.if_valid}, 32'd0);
        boj = 1'b1; npc = 32'hFFFF_FFFC;
        cyc();
        boj = 1'b0;
        cyc();
        chk("wrap_pc", 1, b1.pc, 32'h0);
        chk("wrap_pc4", 1, b1.if_pc4, 32'h0);
        boj = 1'b1; npc = 32'h3102;
        cyc();
        boj = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        chk("adel_pc", 1, b1.pc, 32'h4180);
        chk("adel_pulse", 1, {31'b0, b1.adel}, 32'd1);
        chk("adel_epc", 1, b1.epc, 32'h3102);
        cyc();
        chk("adel_clear", 1, {31'b0, b1.adel}, 32'd0);
`else
        chk("align_pc", 1, b1.pc, 32'h3100);
`endif
        rdy = 1'b0; boj = 1'b1; npc = 32'h3300;
        cyc();
        boj = 1'b0; reset = 1'b1;
        cyc();
        chk("rst_redir_pc", 1, b1.pc, 32'h3000);
        chk("rst_redir_pend", 1, {31'b0, b1.redirect_pend}, 32'd0);
        reset = 1'b0; rdy = 1'b1;
        cyc();
        chk("rst_discard_pc", 1, b1.pc, 32'h3004);
        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(63) == 0;
            stall = $urandom_range(4) == 0;
            rdy   = $urandom_range(3) != 0;
            boj   = $urandom_range(3) == 0;
            npc   = $urandom;
            if ($urandom_range(1) == 0) npc[1:0] = 2'b00;
            instr = $urandom;
            cyc();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
